// File: rtl/inst_encoder.sv
// Instruction encoder: turns a decoded request back into a 32-bit word and queues it, address-tagged, in a 2-entry FIFO.
// Optional macro INST_ENCODER_STRICT_EN makes illegal requests set a sticky err that blocks input until err_clr.
module inst_encoder #(
   parameter int unsigned        ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        inst_type,
   input  logic [3:0]        alu_ctrl,
   input  logic [2:0]        branch_ctrl,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_pulse,
   input  logic              err_clr,
   output logic              err
);

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0000011;
   localparam logic [6:0] OPC_U = 7'b0110111;
   localparam logic [6:0] OPC_S = 7'b0100011;
   localparam logic [6:0] OPC_B = 7'b1100011;
   localparam logic [6:0] OPC_J = 7'b1101111;

   logic [31:0]       word0_q, word0_d, word1_q, word1_d;
   logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;
   logic [1:0]        count_q, count_d;
   logic              errPulse_q, errPulse_d;
   logic              err_q, err_d;

   logic        legal;
   logic        isShift;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] newWord;
   logic        accept, push, pop;

   // Field assembly; legal drops low for any type/control code with no encoding.
   always_comb begin
      legal   = 1'b1;
      isShift = 1'b0;
      funct3  = 3'b000;
      funct7  = 7'b0000000;
      newWord = 32'h0;
      case (inst_type)
         3'b000: begin
            case (alu_ctrl)
               4'b0010: funct3 = 3'b000;
               4'b0100: begin funct3 = 3'b000; funct7 = 7'b0100000; end
               4'b0011: funct3 = 3'b001;
               4'b1000: funct3 = 3'b010;
               4'b0111: funct3 = 3'b100;
               4'b0101: funct3 = 3'b101;
               4'b1001: begin funct3 = 3'b101; funct7 = 7'b0100000; end
               4'b0001: funct3 = 3'b110;
               4'b0000: funct3 = 3'b111;
               default: legal = 1'b0;
            endcase
            newWord = {funct7, rs2, rs1, funct3, rd, OPC_R};
         end
         3'b011: begin
            case (alu_ctrl)
               4'b0010: funct3 = 3'b000;
               4'b1000: funct3 = 3'b010;
               4'b0111: funct3 = 3'b011;
               4'b0001: funct3 = 3'b100;
               4'b0011: begin funct3 = 3'b001; isShift = 1'b1; end
               4'b0101: begin funct3 = 3'b101; isShift = 1'b1; end
               4'b1001: begin funct3 = 3'b101; isShift = 1'b1; funct7 = 7'b0100000; end
               default: legal = 1'b0;
            endcase
            if (isShift) begin
               newWord = {funct7, imm[4:0], rs1, funct3, rd, OPC_I};
            end else begin
               newWord = {imm[11:0], rs1, funct3, rd, OPC_I};
            end
         end
         3'b001: newWord = {imm[31:12], rd, OPC_U};
         3'b100: newWord = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_S};
         3'b101: begin
            case (branch_ctrl)
               3'b000:  funct3 = 3'b000;
               3'b001:  funct3 = 3'b001;
               3'b010:  funct3 = 3'b100;
               3'b011:  funct3 = 3'b101;
               3'b100:  funct3 = 3'b110;
               3'b101:  funct3 = 3'b111;
               default: legal = 1'b0;
            endcase
            newWord = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_B};
         end
         3'b010: newWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_J};
         default: legal = 1'b0;
      endcase
   end

   assign in_ready  = (count_q != 2'd2) && !err_q;
   assign out_valid = (count_q != 2'd0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && legal;
   assign pop       = out_valid && out_ready;

   // Slot 0 is always the head; a push lands in slot 0 whenever that slot is free or being vacated.
   always_comb begin
      word0_d    = word0_q;
      word1_d    = word1_q;
      addr0_d    = addr0_q;
      addr1_d    = addr1_q;
      addrCnt_d  = addrCnt_q;
      count_d    = count_q;
      errPulse_d = accept && !legal;
      if (pop && (count_q == 2'd2)) begin
         word0_d = word1_q;
         addr0_d = addr1_q;
      end
      if (push) begin
         if ((count_q == 2'd0) || pop) begin
            word0_d = newWord;
            addr0_d = addrCnt_q;
         end else begin
            word1_d = newWord;
            addr1_d = addrCnt_q;
         end
         addrCnt_d = addrCnt_q + ADDR_W'(4);
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!push && pop) begin
         count_d = count_q - 2'd1;
      end
   end

`ifdef INST_ENCODER_STRICT_EN
   // A new illegal accept takes priority over a simultaneous clear.
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (accept && !legal) begin
         err_d = 1'b1;
      end
   end
`else
   logic unusedErrClr;
   assign unusedErrClr = err_clr;
   assign err_d        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         word0_q    <= '0;
         word1_q    <= '0;
         addr0_q    <= '0;
         addr1_q    <= '0;
         addrCnt_q  <= BASE_ADDR;
         count_q    <= 2'd0;
         errPulse_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         word0_q    <= word0_d;
         word1_q    <= word1_d;
         addr0_q    <= addr0_d;
         addr1_q    <= addr1_d;
         addrCnt_q  <= addrCnt_d;
         count_q    <= count_d;
         errPulse_q <= errPulse_d;
         err_q      <= err_d;
      end
   end

   assign out_word  = word0_q;
   assign out_addr  = addr0_q;
   assign err_pulse = errPulse_q;
   assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: randomized requests, a reference encoder model, and a wrap-checking 4-bit-address twin.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [2:0]  inst_type;
   logic [3:0]  alu_ctrl;
   logic [2:0]  branch_ctrl;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [31:0] out_word, out_word2;
   logic [31:0] out_addr;
   logic [3:0]  out_addr2;
   logic        err_pulse, err_pulse2;
   logic        err_clr;
   logic        err, err2;

   always #5 clk = ~clk;

   inst_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .inst_type(inst_type), .alu_ctrl(alu_ctrl), .branch_ctrl(branch_ctrl),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
      .err_pulse(err_pulse), .err_clr(err_clr), .err(err)
   );

   inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dutSmall (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .inst_type(inst_type), .alu_ctrl(alu_ctrl), .branch_ctrl(branch_ctrl),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid2), .out_ready(out_ready), .out_word(out_word2), .out_addr(out_addr2),
      .err_pulse(err_pulse2), .err_clr(err_clr), .err(err2)
   );

   typedef struct {
      logic [31:0] word;
      int          idx;
   } expT;

   expT expQ[$];
   bit  illegalAt[int];
   int  pushIdx  = 0;
   int  cycle    = 0;
   int  checks   = 0;
   int  failures = 0;
   int  readyMode = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference encoder written directly from the field tables with plain arithmetic.
   function automatic bit modelEncode(input logic [2:0] t, input logic [3:0] a, input logic [2:0] b,
                                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [31:0] im, output logic [31:0] w);
      int f3 = 0;
      int f7 = 0;
      bit ok = 1;
      bit shamt = 0;
      w = 32'h0;
      case (t)
         3'd0: begin
            case (a)
               4'd2: f3 = 0;
               4'd4: begin f3 = 0; f7 = 32; end
               4'd3: f3 = 1;
               4'd8: f3 = 2;
               4'd7: f3 = 4;
               4'd5: f3 = 5;
               4'd9: begin f3 = 5; f7 = 32; end
               4'd1: f3 = 6;
               4'd0: f3 = 7;
               default: ok = 0;
            endcase
            w = 32'(f7) * 32'h0200_0000 + 32'(s2) * 32'h0010_0000 + 32'(s1) * 32'h8000
              + 32'(f3) * 32'h1000 + 32'(d) * 32'h80 + 32'h33;
         end
         3'd3: begin
            case (a)
               4'd2: f3 = 0;
               4'd8: f3 = 2;
               4'd7: f3 = 3;
               4'd1: f3 = 4;
               4'd3: begin f3 = 1; shamt = 1; end
               4'd5: begin f3 = 5; shamt = 1; end
               4'd9: begin f3 = 5; shamt = 1; f7 = 32; end
               default: ok = 0;
            endcase
            if (shamt)
               w = 32'(f7) * 32'h0200_0000 + (im % 32) * 32'h0010_0000;
            else
               w = (im % 4096) * 32'h0010_0000;
            w = w + 32'(s1) * 32'h8000 + 32'(f3) * 32'h1000 + 32'(d) * 32'h80 + 32'h03;
         end
         3'd1: w = (im & 32'hFFFF_F000) + 32'(d) * 32'h80 + 32'h37;
         3'd4: w = ((im / 32) % 128) * 32'h0200_0000 + 32'(s2) * 32'h0010_0000 + 32'(s1) * 32'h8000
                 + 32'h2000 + (im % 32) * 32'h80 + 32'h23;
         3'd5: begin
            case (b)
               3'd0: f3 = 0;
               3'd1: f3 = 1;
               3'd2: f3 = 4;
               3'd3: f3 = 5;
               3'd4: f3 = 6;
               3'd5: f3 = 7;
               default: ok = 0;
            endcase
            w = ((im / 4096) % 2) * 32'h8000_0000 + ((im / 32) % 64) * 32'h0200_0000
              + 32'(s2) * 32'h0010_0000 + 32'(s1) * 32'h8000 + 32'(f3) * 32'h1000
              + ((im / 2) % 16) * 32'h100 + ((im / 2048) % 2) * 32'h80 + 32'h63;
         end
         3'd2: w = ((im / 32'h10_0000) % 2) * 32'h8000_0000 + ((im / 2) % 1024) * 32'h0020_0000
                 + ((im / 2048) % 2) * 32'h0010_0000 + ((im / 4096) % 256) * 32'h1000
                 + 32'(d) * 32'h80 + 32'h6F;
         default: ok = 0;
      endcase
      return ok;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT hands over its head word.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("err_pulse", 64'(err_pulse), 64'(illegalAt.exists(cycle - 1)));
`ifndef INST_ENCODER_STRICT_EN
         checkOutput("err_tied_low", 64'(err), 64'd0);
`endif
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_word: got 0x%0h expected no output", out_word);
            end else begin
               expT e;
               e = expQ.pop_front();
               checkOutput("out_word", 64'(out_word), 64'(e.word));
               checkOutput("out_addr", 64'(out_addr), 64'(e.idx) * 64'd4);
               checkOutput("out_addr_wrap", 64'(out_addr2), 64'((12 + 4 * e.idx) % 16));
            end
         end
      end
   end

   // Offers one request for one cycle; called at posedge+#1, returns at the next posedge+#1.
   task automatic applyStimulus(input logic [2:0] t, input logic [3:0] a, input logic [2:0] b,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, output bit accepted, output bit legal);
      logic [31:0] w;
      inst_type = t; alu_ctrl = a; branch_ctrl = b;
      rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      if (readyMode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (readyMode == 0);
      @(negedge clk);
      accepted = in_valid && in_ready;
      legal = modelEncode(t, a, b, d, s1, s2, im, w);
      if (accepted) begin
         if (legal) begin
            expQ.push_back('{w, pushIdx});
            pushIdx++;
         end else begin
            illegalAt[cycle] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic clearErr();
`ifdef INST_ENCODER_STRICT_EN
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
`endif
   endtask

   task automatic offerUntilAccepted(input logic [2:0] t, input logic [3:0] a, input logic [2:0] b,
                                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [31:0] im, output bit legal);
      bit acc = 0;
      for (int tries = 0; tries < 30 && !acc; tries++) begin
         applyStimulus(t, a, b, d, s1, s2, im, acc, legal);
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: got no accept expected accept within 30 cycles");
      end
   endtask

   task automatic doReset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      pushIdx = 0;
   endtask

   initial begin
      bit acc, legal;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      inst_type = '0; alu_ctrl = '0; branch_ctrl = '0;
      rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_out_word", 64'(out_word), 64'd0);
      checkOutput("reset_out_addr", 64'(out_addr), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_err", 64'(err), 64'd0);
      @(posedge clk);
      #1;

      // ADD must reach the head one cycle after acceptance.
      readyMode = 0;
      offerUntilAccepted(3'd0, 4'd2, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0, legal);
      @(negedge clk);
      checkOutput("add_latency_valid", 64'(out_valid), 64'd1);
      checkOutput("add_word", 64'(out_word), 64'h003100B3);
      @(posedge clk);
      #1;

      offerUntilAccepted(3'd0, 4'd4, 3'd0, 5'd5, 5'd6, 5'd7, 32'h0, legal);
      offerUntilAccepted(3'd5, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'h8, legal);
      offerUntilAccepted(3'd1, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345000, legal);
      repeat (3) @(posedge clk);
      #1;

      // Fill the FIFO, then reset it mid-operation.
      readyMode = 1;
      applyStimulus(3'd0, 4'd2, 3'd0, 5'd1, 5'd1, 5'd1, 32'h0, acc, legal);
      applyStimulus(3'd0, 4'd2, 3'd0, 5'd2, 5'd2, 5'd2, 32'h0, acc, legal);
      doReset();
      @(negedge clk);
      checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Backpressure: third request must be held until the consumer drains.
      applyStimulus(3'd0, 4'd3, 3'd0, 5'd3, 5'd4, 5'd5, 32'h0, acc, legal);
      checkOutput("bp_first_accept", 64'(acc), 64'd1);
      applyStimulus(3'd3, 4'd2, 3'd0, 5'd6, 5'd7, 5'd0, 32'h7FF, acc, legal);
      checkOutput("bp_second_accept", 64'(acc), 64'd1);
      applyStimulus(3'd4, 4'd0, 3'd0, 5'd0, 5'd8, 5'd9, 32'hABC, acc, legal);
      checkOutput("bp_third_held", 64'(acc), 64'd0);
      readyMode = 0;
      offerUntilAccepted(3'd4, 4'd0, 3'd0, 5'd0, 5'd8, 5'd9, 32'hABC, legal);
      repeat (3) @(posedge clk);
      #1;

      // Illegal type: pulse only, no push, address not advanced.
      applyStimulus(3'd7, 4'd2, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0, acc, legal);
      checkOutput("illegal_accept", 64'(acc), 64'd1);
      @(negedge clk);
      checkOutput("illegal_no_valid", 64'(out_valid), 64'd0);
`ifdef INST_ENCODER_STRICT_EN
      checkOutput("strict_err_set", 64'(err), 64'd1);
      checkOutput("strict_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      clearErr();
      @(negedge clk);
      checkOutput("strict_err_cleared", 64'(err), 64'd0);
      checkOutput("strict_in_ready_back", 64'(in_ready), 64'd1);
`else
      checkOutput("illegal_in_ready", 64'(in_ready), 64'd1);
`endif
      @(posedge clk);
      #1;
      offerUntilAccepted(3'd2, 4'd0, 3'd0, 5'd31, 5'd0, 5'd0, 32'h001F_F7FE, legal);

      // Randomized phase with random consumer stalls.
      readyMode = 2;
      for (int n = 0; n < 250; n++) begin
         logic [2:0] t;
         t = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
         offerUntilAccepted(t, 4'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                            5'($urandom), $urandom, legal);
         if (!legal) clearErr();
      end

      readyMode = 0;
      out_ready = 1'b1;
      for (int w = 0; w < 20 && expQ.size() != 0; w++) @(posedge clk);
      #1;
      checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
